// File: rtl/mem_stage_ctrl_pkg.sv
// Shared types and constants for the MEM pipeline stage.
package mem_stage_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic [3:0] BE_WORD = 4'hF;
  localparam logic [3:0] BE_NONE = 4'h0;

  // Bit positions of the EX/MEM control word.
  localparam int CTL_MEMREAD  = 2;
  localparam int CTL_MEMWRITE = 4;
  localparam int CTL_REGWRITE = 6;
  localparam int CTL_WORD     = 8;

  localparam int REG_W = 5;

  function automatic logic [3:0] byte_be(input logic [1:0] off);
    return 4'b0001 << off;
  endfunction

endpackage

// File: rtl/mem_stage_ctrl_lane_align.sv
// Load byte extraction and store lane replication / byte-enable generation.
module mem_stage_ctrl_lane_align
  import mem_stage_ctrl_pkg::*;
(
  input  logic [1:0]  i_ld_off,
  input  logic        i_ld_word,
  input  logic [31:0] i_rdata,
  output logic [31:0] o_ld_data,
  input  logic [1:0]  i_st_off,
  input  logic        i_st_word,
  input  logic        i_st_write,
  input  logic [31:0] i_st_data,
  output logic [31:0] o_st_wdata,
  output logic [3:0]  o_st_be
);

  logic [7:0] w_ld_byte;

  assign w_ld_byte  = i_rdata[8*i_ld_off +: 8];
  assign o_ld_data  = i_ld_word ? i_rdata : {24'b0, w_ld_byte};
  assign o_st_wdata = i_st_word ? i_st_data : {4{i_st_data[7:0]}};

  always_comb begin
    o_st_be = BE_NONE;
    if (i_st_write) o_st_be = i_st_word ? BE_WORD : byte_be(i_st_off);
  end

endmodule

// File: rtl/mem_stage_ctrl.sv
// MEM stage: req/ack data-memory port, upstream stall and MEM/WB register.
// Define MISALIGN_TRAP_EN to trap misaligned word accesses instead of forcing alignment.
module mem_stage_ctrl
  import mem_stage_ctrl_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [DATA_W-1:0] inResult,
  input  logic [DATA_W-1:0] inReadRegister2,
  input  logic              inMemRead,
  input  logic              inMemWrite,
  input  logic              inWord,
  input  logic              inRegWrite,
  input  logic [REG_W-1:0]  inRd,
  output logic [ADDR_W-1:0] memAddr,
  output logic [DATA_W-1:0] memWData,
  output logic [3:0]        memByteEn,
  output logic              memReq,
  output logic              memWe,
  input  logic [DATA_W-1:0] memRData,
  input  logic              memAck,
  output logic              stall,
  output logic [DATA_W-1:0] outData,
  output logic [REG_W-1:0]  outRd,
  output logic              outRegWrite,
  output logic              outMisalign
);

  state_e            r_state, w_state_nxt;
  logic [1:0]        r_ld_off;
  logic              r_ld_word;
  logic              r_is_load;
  logic [DATA_W-1:0] r_ld_data;
  logic              w_access, w_misalign, w_start;
  logic [DATA_W-1:0] w_ld_data, w_st_wdata;
  logic [3:0]        w_st_be;

  assign w_access = inMemRead | inMemWrite;

`ifdef MISALIGN_TRAP_EN
  assign w_misalign = w_access & inWord & (inResult[1:0] != 2'b00);
`else
  assign w_misalign = 1'b0;
`endif

  assign w_start = (r_state == ST_IDLE) & w_access & ~w_misalign;
  // Gated by reset so every output reads 0 while reset is held.
  assign stall   = reset & (w_start | (r_state == ST_WAIT));

  mem_stage_ctrl_lane_align u_lane_align (
    .i_ld_off   (r_ld_off),
    .i_ld_word  (r_ld_word),
    .i_rdata    (memRData),
    .o_ld_data  (w_ld_data),
    .i_st_off   (inResult[1:0]),
    .i_st_word  (inWord),
    .i_st_write (inMemWrite),
    .i_st_data  (inReadRegister2),
    .o_st_wdata (w_st_wdata),
    .o_st_be    (w_st_be)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_start) w_state_nxt = ST_WAIT;
      ST_WAIT: if (memAck)  w_state_nxt = ST_DONE;
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      memReq      <= 1'b0;
      memWe       <= 1'b0;
      memAddr     <= '0;
      memWData    <= '0;
      memByteEn   <= BE_NONE;
      r_ld_off    <= 2'b00;
      r_ld_word   <= 1'b0;
      r_is_load   <= 1'b0;
      r_ld_data   <= '0;
      outData     <= '0;
      outRd       <= '0;
      outRegWrite <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_start) begin
            memReq      <= 1'b1;
            memWe       <= inMemWrite;
            memAddr     <= {inResult[ADDR_W-1:2], 2'b00};
            memWData    <= w_st_wdata;
            memByteEn   <= w_st_be;
            r_ld_off    <= inResult[1:0];
            r_ld_word   <= inWord;
            r_is_load   <= ~inMemWrite;
            outRegWrite <= 1'b0;
          end else begin
            outData     <= inResult;
            outRd       <= inRd;
            outRegWrite <= inRegWrite & ~w_misalign;
          end
        end
        ST_WAIT: begin
          outRegWrite <= 1'b0;
          if (memAck) begin
            memReq    <= 1'b0;
            r_ld_data <= w_ld_data;
          end
        end
        ST_DONE: begin
          // Same instruction is still presented upstream; consume it here, never re-issue.
          outData     <= r_is_load ? r_ld_data : inResult;
          outRd       <= inRd;
          outRegWrite <= inRegWrite;
        end
        default: outRegWrite <= 1'b0;
      endcase
    end
  end

`ifdef MISALIGN_TRAP_EN
  logic r_misalign;
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) r_misalign <= 1'b0;
    else        r_misalign <= (r_state == ST_IDLE) & w_misalign;
  end
  assign outMisalign = r_misalign;
`else
  assign outMisalign = 1'b0;
`endif

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Directed plus randomized bench for mem_stage_ctrl against a transaction-level model.
module tb_mem_stage_ctrl;

  logic        clock, reset;
  logic [31:0] inResult, inReadRegister2, memRData;
  logic        inMemRead, inMemWrite, inWord, inRegWrite, memAck;
  logic [4:0]  inRd;
  logic [31:0] memAddr, memWData, outData;
  logic [3:0]  memByteEn;
  logic        memReq, memWe, stall, outRegWrite, outMisalign;
  logic [4:0]  outRd;

  int pass_cnt = 0;
  int fail_cnt = 0;
  int total_cnt = 0;

  mem_stage_ctrl dut (
    .clock(clock), .reset(reset),
    .inResult(inResult), .inReadRegister2(inReadRegister2),
    .inMemRead(inMemRead), .inMemWrite(inMemWrite), .inWord(inWord),
    .inRegWrite(inRegWrite), .inRd(inRd),
    .memAddr(memAddr), .memWData(memWData), .memByteEn(memByteEn),
    .memReq(memReq), .memWe(memWe), .memRData(memRData), .memAck(memAck),
    .stall(stall), .outData(outData), .outRd(outRd),
    .outRegWrite(outRegWrite), .outMisalign(outMisalign)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference model: what the memory and write-back should see for one instruction.
  function automatic logic [31:0] m_load(input logic [31:0] rd, input logic word, input logic [1:0] off);
    if (word) return rd;
    return (rd >> (8 * off)) & 32'hFF;
  endfunction

  function automatic logic [3:0] m_be(input logic wr, input logic word, input logic [1:0] off);
    int v;
    if (!wr) return 4'h0;
    if (word) return 4'hF;
    v = 1 << off;
    return v[3:0];
  endfunction

  function automatic logic [31:0] m_wdata(input logic [31:0] rs2, input logic word);
    if (word) return rs2;
    return {24'b0, rs2[7:0]} * 32'h01010101;
  endfunction

  task automatic run_txn(input logic [31:0] res, input logic [31:0] rs2,
                         input logic mr, input logic mw, input logic wd, input logic rw,
                         input logic [4:0] rd, input logic [31:0] rdata, input int n,
                         input string nm);
    logic acc, mis;
    logic [31:0] expd;
    acc = mr | mw;
`ifdef MISALIGN_TRAP_EN
    mis = acc && wd && (res[1:0] != 2'b00);
`else
    mis = 1'b0;
`endif
    inResult = res; inReadRegister2 = rs2; inMemRead = mr; inMemWrite = mw;
    inWord = wd; inRegWrite = rw; inRd = rd; memAck = 1'b0;
    #1;
    if (!acc || mis) begin
      chk({nm, " stall"}, {31'b0, stall}, 32'd0);
      @(posedge clock); #1;
      chk({nm, " outData"}, outData, res);
      chk({nm, " outRd"}, {27'b0, outRd}, {27'b0, rd});
      chk({nm, " outRegWrite"}, {31'b0, outRegWrite}, {31'b0, rw & ~mis});
      chk({nm, " outMisalign"}, {31'b0, outMisalign}, {31'b0, mis});
      chk({nm, " memReq"}, {31'b0, memReq}, 32'd0);
    end else begin
      chk({nm, " stall0"}, {31'b0, stall}, 32'd1);
      expd = mw ? res : m_load(rdata, wd, res[1:0]);
      for (int k = 0; k <= n; k++) begin
        @(posedge clock); #1;
        chk({nm, " memReq"}, {31'b0, memReq}, 32'd1);
        chk({nm, " memAddr"}, memAddr, res & ~32'd3);
        chk({nm, " memWe"}, {31'b0, memWe}, {31'b0, mw});
        chk({nm, " memByteEn"}, {28'b0, memByteEn}, {28'b0, m_be(mw, wd, res[1:0])});
        if (mw) chk({nm, " memWData"}, memWData, m_wdata(rs2, wd));
        chk({nm, " stallW"}, {31'b0, stall}, 32'd1);
        chk({nm, " bubble"}, {31'b0, outRegWrite}, 32'd0);
        memRData = (k == n) ? rdata : $urandom;
        memAck = (k == n);
      end
      @(posedge clock); #1;
      memAck = 1'b0; memRData = $urandom;
      chk({nm, " reqDrop"}, {31'b0, memReq}, 32'd0);
      #1;
      chk({nm, " stallDone"}, {31'b0, stall}, 32'd0);
      @(posedge clock); #1;
      chk({nm, " outData"}, outData, expd);
      chk({nm, " outRd"}, {27'b0, outRd}, {27'b0, rd});
      chk({nm, " outRegWrite"}, {31'b0, outRegWrite}, {31'b0, rw});
      chk({nm, " outMisalign"}, {31'b0, outMisalign}, 32'd0);
    end
  endtask

  initial begin
    logic mr, mw;
    reset = 1'b0;
    inResult = '0; inReadRegister2 = '0; inMemRead = 0; inMemWrite = 0;
    inWord = 0; inRegWrite = 0; inRd = '0; memRData = '0; memAck = 0;
    #12;
    chk("rst memReq", {31'b0, memReq}, 32'd0);
    chk("rst memWe", {31'b0, memWe}, 32'd0);
    chk("rst memAddr", memAddr, 32'd0);
    chk("rst memWData", memWData, 32'd0);
    chk("rst memByteEn", {28'b0, memByteEn}, 32'd0);
    chk("rst outData", outData, 32'd0);
    chk("rst outRd", {27'b0, outRd}, 32'd0);
    chk("rst outRegWrite", {31'b0, outRegWrite}, 32'd0);
    chk("rst outMisalign", {31'b0, outMisalign}, 32'd0);
    @(negedge clock); reset = 1'b1;
    @(posedge clock); #1;

    run_txn(32'h1234, 32'h0, 0, 0, 0, 1, 5'd7, 32'h0, 0, "alu");
    run_txn(32'h100, 32'h0, 1, 0, 1, 1, 5'd5, 32'hDEADBEEF, 2, "wload");
    run_txn(32'h203, 32'hA5, 0, 1, 0, 0, 5'd0, 32'h0, 0, "bstore");
    run_txn(32'h302, 32'h0, 1, 0, 0, 1, 5'd9, 32'h11223344, 1, "bload");
    run_txn(32'h101, 32'h0, 1, 0, 1, 1, 5'd3, 32'hCAFEF00D, 0, "misword");
    run_txn(32'h40, 32'h55667788, 1, 1, 1, 0, 5'd4, 32'h99, 0, "rdwr");
    run_txn(32'h4321, 32'h0, 0, 0, 0, 1, 5'd12, 32'h0, 0, "alu2");

    // Reset mid-access, then a stray ack must not be taken as load data.
    inResult = 32'h500; inMemRead = 1; inMemWrite = 0; inWord = 1; inRegWrite = 1; inRd = 5'd6;
    @(posedge clock); #1;
    chk("midrst req before", {31'b0, memReq}, 32'd1);
    #2 reset = 1'b0;
    #1;
    chk("midrst memReq", {31'b0, memReq}, 32'd0);
    chk("midrst memAddr", memAddr, 32'd0);
    chk("midrst stall", {31'b0, stall}, 32'd0);
    chk("midrst outData", outData, 32'd0);
    chk("midrst outRegWrite", {31'b0, outRegWrite}, 32'd0);
    inResult = 32'h777; inMemRead = 0; inRd = 5'd2; inRegWrite = 1;
    memAck = 1'b1; memRData = 32'hBADBAD00;
    @(negedge clock); reset = 1'b1;
    @(posedge clock); #1;
    chk("lateack memReq", {31'b0, memReq}, 32'd0);
    chk("lateack outData", outData, 32'h777);
    chk("lateack outRd", {27'b0, outRd}, 32'd2);
    memAck = 1'b0;

    for (int t = 0; t < 40; t++) begin
      if ($urandom_range(0, 2) == 0) begin
        mr = 0; mw = 0;
      end else begin
        mr = 1'($urandom); mw = 1'($urandom);
        if (!mr && !mw) mr = 1;
      end
      run_txn($urandom, $urandom, mr, mw, 1'($urandom), 1'($urandom),
              5'($urandom), $urandom, $urandom_range(0, 3), "rnd");
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
